mem_resp: RTL and testbench

// - Byte-wide memory responder: the far end of the mem_ctrl byte bus. Accepts one addr/wr/wdata beat per cycle,

---
 rtl/mem_resp.sv | 153 +++++++++++++++
 tb/tb_mem_resp.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_resp.sv
// ----------------------------------------------------------------------------
// mem_resp -- byte-wide memory responder at the far end of the mem_ctrl bus.
//
// Every clock is one bus beat. There is no handshake and no backpressure.
// A read beat returns its byte on rdata RD_LATENCY cycles after the edge that
// samples addr. A write beat stores wdata at that edge. addr[ADDR_WIDTH-1]=1
// selects a small I/O window instead of RAM:
//   off 0  write: tx byte. read: rx byte, which pops the rx source.
//   off 1  read : status {5'b0, overflow, rx_valid, tx_empty}
//   off 2/3     : read 0, writes ignored
//
// Ports
//   clk, rst          clock (posedge) and synchronous active-high reset
//   mem_ctrl_wr       1 = write beat, 0 = read beat
//   addr, wdata       beat address and write byte
//   rdata             read byte, delayed RD_LATENCY cycles
//   io_tx_data/valid  tx byte held until io_tx_ready
//   io_tx_ready       tx sink accepts at posedge when valid&ready
//   io_rx_data/valid  incoming byte
//   io_rx_pop         1-cycle pulse after an off-0 read consumed the rx byte
//   io_overflow       sticky: an off-0 write was dropped because tx was full
//
// Optional feature: define MEM_RESP_STATS_EN to add rd_cnt/wr_cnt beat
// counters. These are free-running 32-bit counters of read and write beats.
// ----------------------------------------------------------------------------
module mem_resp #(
    parameter int ADDR_WIDTH = 17,
    parameter int RAM_AW     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ctrl_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata,
    output logic [7:0]            io_tx_data,
    output logic                  io_tx_valid,
    input  logic                  io_tx_ready,
    input  logic [7:0]            io_rx_data,
    input  logic                  io_rx_valid,
    output logic                  io_rx_pop,
`ifdef MEM_RESP_STATS_EN
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt,
`endif
    output logic                  io_overflow
);

    logic [7:0] ram_q [2**RAM_AW];

    logic [7:0] pipe_q [RD_LATENCY];
    logic [7:0] stage0_d;

    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       ovf_q, ovf_d;
    logic       pop_q, pop_d;

    logic              is_io;
    logic [1:0]        off;
    logic [RAM_AW-1:0] idx;
    logic              tx_fire;
    logic              tx_wr;

    assign is_io   = addr[ADDR_WIDTH-1];
    assign off     = addr[1:0];
    assign idx     = addr[RAM_AW-1:0];
    assign tx_fire = tx_valid_q & io_tx_ready;
    assign tx_wr   = mem_ctrl_wr & is_io & (off == 2'd0);

    // Read-data selection for stage 0. A write beat injects 0 into the pipe.
    always_comb begin
        stage0_d = 8'h00;
        if (!mem_ctrl_wr) begin
            if (!is_io) begin
                stage0_d = ram_q[idx];
            end else begin
                unique case (off)
                    2'd0:    stage0_d = io_rx_valid ? io_rx_data : 8'h00;
                    2'd1:    stage0_d = {5'b0, ovf_q, io_rx_valid, ~tx_valid_q};
                    default: stage0_d = 8'h00;
                endcase
            end
        end
    end

    // The tx slot can be reloaded on the same edge that drains it. A write
    // arriving while the slot is full and not draining is dropped and
    // recorded in the sticky overflow flag.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        ovf_d      = ovf_q;
        pop_d      = !mem_ctrl_wr && is_io && (off == 2'd0) && io_rx_valid;
        if (tx_fire) tx_valid_d = 1'b0;
        if (tx_wr) begin
            if (!tx_valid_q || tx_fire) begin
                tx_data_d  = wdata;
                tx_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // The RAM is not reset. Beats that arrive while rst is high are ignored.
    always_ff @(posedge clk) begin
        if (!rst && mem_ctrl_wr && !is_io) ram_q[idx] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            pop_q      <= 1'b0;
        end else begin
            pipe_q[0] <= stage0_d;
            for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
            pop_q      <= pop_d;
        end
    end

    assign rdata       = pipe_q[RD_LATENCY-1];
    assign io_tx_data  = tx_data_q;
    assign io_tx_valid = tx_valid_q;
    assign io_overflow = ovf_q;
    assign io_rx_pop   = pop_q;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (mem_ctrl_wr) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_resp.sv
module tb_mem_resp;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ctrl_wr = 1'b0;
    logic [16:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready = 1'b0;
    logic [7:0]  io_rx_data = '0;
    logic        io_rx_valid = 1'b0;
    logic        io_rx_pop;
    logic        io_overflow;
`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_cnt, wr_cnt;
`endif

    mem_resp #(.ADDR_WIDTH(17), .RAM_AW(16), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .mem_ctrl_wr(mem_ctrl_wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .io_tx_data(io_tx_data),
        .io_tx_valid(io_tx_valid), .io_tx_ready(io_tx_ready),
        .io_rx_data(io_rx_data), .io_rx_valid(io_rx_valid),
        .io_rx_pop(io_rx_pop),
`ifdef MEM_RESP_STATS_EN
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
`endif
        .io_overflow(io_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [7:0]  exp;
        logic [16:0] a;
    } sb_t;
    sb_t sbq[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // The monitor retires expected read bytes on the cycle they are due.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            sb_t e;
            e = sbq.pop_front();
            chk($sformatf("rdata@%05h", e.a), {24'h0, rdata}, {24'h0, e.exp});
        end
    end

    // One beat: inputs are driven just after a posedge. If expect_rd is set,
    // the expected byte is queued for the cycle LAT edges after sampling.
    task automatic beat(input logic w, input logic [16:0] a, input logic [7:0] d,
                        input bit expect_rd, input logic [7:0] exp);
        mem_ctrl_wr = w;
        addr = a;
        wdata = d;
        if (expect_rd) sbq.push_back('{due: cyc + LAT, exp: exp, a: a});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

`ifdef MEM_RESP_STATS_EN
    logic [31:0] wr_before;
`endif

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", {24'h0, rdata}, 32'h0);
        chk("rst_tx_valid", {31'h0, io_tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, io_tx_data}, 32'h0);
        chk("rst_rx_pop", {31'h0, io_rx_pop}, 32'h0);
        chk("rst_overflow", {31'h0, io_overflow}, 32'h0);
        rst = 1'b0;

        // Write then read back on the very next beat
        beat(1, 17'h00010, 8'hA5, 0, 8'h00);
        beat(0, 17'h00010, 8'h00, 1, 8'hA5);

        // Back-to-back reads
        beat(1, 17'h00000, 8'h11, 0, 8'h00);
        beat(1, 17'h00001, 8'h22, 0, 8'h00);
        beat(1, 17'h00002, 8'h33, 0, 8'h00);
        beat(1, 17'h00003, 8'h44, 0, 8'h00);
        beat(0, 17'h00000, 8'h00, 1, 8'h11);
        beat(0, 17'h00001, 8'h00, 1, 8'h22);
        beat(0, 17'h00002, 8'h00, 1, 8'h33);
        beat(0, 17'h00003, 8'h00, 1, 8'h44);

        // Highest RAM byte
        beat(1, 17'h0FFFF, 8'hC3, 0, 8'h00);
        beat(0, 17'h0FFFF, 8'h00, 1, 8'hC3);

        // rx read pops the byte; status shows rx_valid and tx empty
        io_rx_valid = 1'b1;
        io_rx_data = 8'h5A;
        beat(0, 17'h10000, 8'h00, 1, 8'h5A);
        chk("rx_pop_pulse", {31'h0, io_rx_pop}, 32'h1);
        beat(0, 17'h10001, 8'h00, 1, 8'h03);
        chk("rx_pop_clear", {31'h0, io_rx_pop}, 32'h0);
        io_rx_valid = 1'b0;
        beat(0, 17'h10000, 8'h00, 1, 8'h00);
        chk("rx_no_pop", {31'h0, io_rx_pop}, 32'h0);
        beat(0, 17'h10002, 8'h00, 1, 8'h00);

        // tx overflow: the second byte is dropped
        io_tx_ready = 1'b0;
        beat(1, 17'h10000, 8'h41, 0, 8'h00);
        chk("tx_valid_set", {31'h0, io_tx_valid}, 32'h1);
        beat(1, 17'h10000, 8'h42, 0, 8'h00);
        chk("tx_data_held", {24'h0, io_tx_data}, 32'h41);
        chk("overflow_set", {31'h0, io_overflow}, 32'h1);
        beat(0, 17'h10001, 8'h00, 1, 8'h04);
        // The tx slot drains and reloads on the same edge
        io_tx_ready = 1'b1;
        beat(1, 17'h10000, 8'h43, 0, 8'h00);
        chk("tx_reload", {24'h0, io_tx_data}, 32'h43);
        chk("tx_reload_valid", {31'h0, io_tx_valid}, 32'h1);
        beat(0, 17'h00000, 8'h00, 0, 8'h00);
        chk("tx_drained", {31'h0, io_tx_valid}, 32'h0);
        chk("overflow_sticky", {31'h0, io_overflow}, 32'h1);
        io_tx_ready = 1'b0;

        // An I/O write to off 1 must leave RAM untouched
        beat(1, 17'h02345, 8'h99, 0, 8'h00);
`ifdef MEM_RESP_STATS_EN
        wr_before = wr_cnt;
`endif
        beat(1, 17'h12345, 8'h77, 0, 8'h00);
`ifdef MEM_RESP_STATS_EN
        chk("wr_cnt_inc", wr_cnt, wr_before + 32'd1);
`endif
        beat(0, 17'h02345, 8'h00, 1, 8'h99);

        // Reset in the middle of a read
        beat(1, 17'h00050, 8'h3C, 0, 8'h00);
        beat(1, 17'h10000, 8'h55, 0, 8'h00);
        beat(0, 17'h00050, 8'h00, 0, 8'h00);
        rst = 1'b1;
        beat(0, 17'h00000, 8'h00, 0, 8'h00);
        chk("midrst_rdata", {24'h0, rdata}, 32'h0);
        chk("midrst_tx_valid", {31'h0, io_tx_valid}, 32'h0);
        chk("midrst_overflow", {31'h0, io_overflow}, 32'h0);
        rst = 1'b0;
        beat(0, 17'h00050, 8'h00, 1, 8'h3C);
        beat(0, 17'h00010, 8'h00, 1, 8'hA5);

        repeat (LAT + 2) beat(0, 17'h00000, 8'h00, 0, 8'h00);
        chk("sb_drained", sbq.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
